// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the two-port memory arbiter: state encodings, port indices, default widths.
package mem_arbiter_pkg;

  localparam int ARB_AW_DEF = 8;
  localparam int ARB_DW_DEF = 8;

  localparam logic ARB_P0 = 1'b0;
  localparam logic ARB_P1 = 1'b1;

  typedef enum logic {
    ARB_IDLE   = 1'b0,
    ARB_ACCESS = 1'b1
  } arb_state_t;

endpackage

// File: rtl/mem_arbiter_arb_pick.sv
// Combinational winner select for the memory arbiter.
// MEM_ARB_RR_EN defined: round-robin on contention; undefined: port 0 always wins.
module arb_pick
  import mem_arbiter_pkg::*;
(
  input  logic [1:0] i_req,
  input  logic [1:0] i_mask,
`ifdef MEM_ARB_RR_EN
  input  logic       i_last_gnt,
`endif
  output logic       o_winner,
  output logic       o_any_valid
);

  logic w_win;

  always_comb begin
    w_win = ARB_P0;
`ifdef MEM_ARB_RR_EN
    if (i_req == 2'b11) w_win = ~i_last_gnt;
    else if (i_req[1])  w_win = ARB_P1;
`else
    if (!i_req[0] && i_req[1]) w_win = ARB_P1;
`endif
  end

  // The winner is chosen from the raw requests first; a masked winner yields no grant,
  // which is what lets a continuously requesting port 0 starve port 1 in fixed priority.
  assign o_winner    = w_win;
  assign o_any_valid = i_req[w_win] & ~i_mask[w_win];

endmodule

// File: rtl/mem_arbiter.sv
// Two-port arbiter sharing one memory between the processor (port 0) and a loader/DMA (port 1).
// Optional round-robin arbitration selected by defining MEM_ARB_RR_EN.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int AW = ARB_AW_DEF,
  parameter int DW = ARB_DW_DEF
)
(
  input  logic          clk,
  input  logic          reset,
  input  logic          req0,
  input  logic          we0,
  input  logic [AW-1:0] addr0,
  input  logic [DW-1:0] wdata0,
  output logic          gnt0,
  output logic          rvalid0,
  input  logic          req1,
  input  logic          we1,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata1,
  output logic          gnt1,
  output logic          rvalid1,
  output logic [DW-1:0] rdata,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic          mem_we,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy
);

  arb_state_t    r_state;
  arb_state_t    w_next_state;
  logic          r_gnt0, r_gnt1;
  logic          r_rvalid0, r_rvalid1;
  logic [DW-1:0] r_rdata;
  logic [AW-1:0] r_mem_addr;
  logic [DW-1:0] r_mem_wdata;
  logic          r_mem_we;
  logic [1:0]    w_req;
  logic          w_winner;
  logic          w_any;
  logic [1:0]    w_gnt_nxt;
  logic          w_ld_we;
  logic [AW-1:0] w_ld_addr;
  logic [DW-1:0] w_ld_wdata;
  logic          w_busy;
`ifdef MEM_ARB_RR_EN
  logic          r_last_gnt;
`endif

  assign w_req = {req1, req0};

  arb_pick u_pick (
    .i_req       (w_req),
    .i_mask      ({r_gnt1, r_gnt0}),
`ifdef MEM_ARB_RR_EN
    .i_last_gnt  (r_last_gnt),
`endif
    .o_winner    (w_winner),
    .o_any_valid (w_any)
  );

  always_ff @(posedge clk) begin
    if (reset) r_state <= ARB_IDLE;
    else       r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ARB_IDLE:   if (w_any) w_next_state = ARB_ACCESS;
      ARB_ACCESS: w_next_state = w_any ? ARB_ACCESS : ARB_IDLE;
    endcase
  end

  always_comb begin
    w_gnt_nxt = 2'b00;
    if (w_any) w_gnt_nxt[w_winner] = 1'b1;
    w_ld_we    = (w_winner == ARB_P1) ? we1    : we0;
    w_ld_addr  = (w_winner == ARB_P1) ? addr1  : addr0;
    w_ld_wdata = (w_winner == ARB_P1) ? wdata1 : wdata0;
    w_busy     = (r_state == ARB_ACCESS);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_gnt0      <= 1'b0;
      r_gnt1      <= 1'b0;
      r_rvalid0   <= 1'b0;
      r_rvalid1   <= 1'b0;
      r_rdata     <= '0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_mem_we    <= 1'b0;
`ifdef MEM_ARB_RR_EN
      r_last_gnt  <= ARB_P1;
`endif
    end else begin
      r_gnt0   <= w_gnt_nxt[0];
      r_gnt1   <= w_gnt_nxt[1];
      r_mem_we <= w_any & w_ld_we;
      if (w_any) begin
        r_mem_addr  <= w_ld_addr;
        r_mem_wdata <= w_ld_wdata;
      end
      // The port granted last cycle just completed its access; only reads report back.
      r_rvalid0 <= r_gnt0 & ~r_mem_we;
      r_rvalid1 <= r_gnt1 & ~r_mem_we;
      if (r_state == ARB_ACCESS) r_rdata <= mem_rdata;
`ifdef MEM_ARB_RR_EN
      if (w_any) r_last_gnt <= w_winner;
`endif
    end
  end

  assign gnt0      = r_gnt0;
  assign gnt1      = r_gnt1;
  assign rvalid0   = r_rvalid0;
  assign rvalid1   = r_rvalid1;
  assign rdata     = r_rdata;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign mem_we    = r_mem_we;
  assign busy      = w_busy;

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized bench for mem_arbiter against a transaction-level reference model and memory.
// Honours MEM_ARB_RR_EN to select the expected arbitration policy.
module tb_mem_arbiter;

  localparam int AW = 8;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          req0 = 1'b0, we0 = 1'b0, req1 = 1'b0, we1 = 1'b0;
  logic [AW-1:0] addr0 = '0, addr1 = '0;
  logic [DW-1:0] wdata0 = '0, wdata1 = '0;
  logic          gnt0, gnt1, rvalid0, rvalid1, mem_we, busy;
  logic [DW-1:0] rdata, mem_wdata, mem_rdata;
  logic [AW-1:0] mem_addr;

  logic [DW-1:0] mem     [256];
  logic [DW-1:0] mem_ref [256];

  typedef struct {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } txn_t;

  txn_t q0[$];
  txn_t q1[$];
  bit   act0, act1, cont;

  // Reference model: which port owns the access cycle, its transfer, and the finished read.
  int            m_cur = -1;
  int            m_rv  = -1;
  int            m_last = 1;
  logic          m_we = 1'b0;
  logic [AW-1:0] m_addr = '0;
  logic [DW-1:0] m_wdata = '0, m_rdata = '0;
  bit            model_ok = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;

  mem_arbiter #(.AW(AW), .DW(DW)) dut (
    .clk(clk), .reset(reset),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0), .gnt0(gnt0), .rvalid0(rvalid0),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1), .gnt1(gnt1), .rvalid1(rvalid1),
    .rdata(rdata), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
    .mem_rdata(mem_rdata), .busy(busy)
  );

  always #5 clk = ~clk;

  assign mem_rdata = mem[mem_addr];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic push(input int p, input logic w, input logic [7:0] a, input logic [7:0] d);
    txn_t t;
    t.we = w; t.addr = a; t.wdata = d;
    if (p == 0) q0.push_back(t);
    else        q1.push_back(t);
  endtask

  task automatic model_edge();
    int w;
    bit elig;
    if (reset) begin
      if (m_cur >= 0 && m_we) mem_ref[m_addr] = m_wdata;
      m_cur = -1; m_rv = -1; m_last = 1;
      m_we = 1'b0; m_addr = '0; m_wdata = '0; m_rdata = '0;
      model_ok = 1'b1;
    end else begin
      m_rv = -1;
      if (m_cur >= 0) begin
        m_rdata = mem_ref[m_addr];
        if (m_we) mem_ref[m_addr] = m_wdata;
        else      m_rv = m_cur;
      end
`ifdef MEM_ARB_RR_EN
      if (req0 && req1) w = 1 - m_last;
      else              w = req1 ? 1 : 0;
`else
      w = req0 ? 0 : (req1 ? 1 : 0);
`endif
      elig = ((w == 0) ? req0 : req1) && (w != m_cur);
      if (elig) begin
        m_cur   = w;
        m_we    = (w == 1) ? we1 : we0;
        m_addr  = (w == 1) ? addr1 : addr0;
        m_wdata = (w == 1) ? wdata1 : wdata0;
        m_last  = w;
      end else begin
        m_cur = -1;
        m_we  = 1'b0;
      end
    end
  endtask

  task automatic step(input bit rst_in);
    logic          wr_pend;
    logic [AW-1:0] wr_a;
    logic [DW-1:0] wr_d;
    @(negedge clk);
    if (model_ok) begin
      check_eq("gnt0",      32'(gnt0),      32'(m_cur == 0));
      check_eq("gnt1",      32'(gnt1),      32'(m_cur == 1));
      check_eq("busy",      32'(busy),      32'(m_cur >= 0));
      check_eq("mem_we",    32'(mem_we),    32'(m_we));
      check_eq("mem_addr",  32'(mem_addr),  32'(m_addr));
      check_eq("mem_wdata", 32'(mem_wdata), 32'(m_wdata));
      check_eq("rvalid0",   32'(rvalid0),   32'(m_rv == 0));
      check_eq("rvalid1",   32'(rvalid1),   32'(m_rv == 1));
      check_eq("rdata",     32'(rdata),     32'(m_rdata));
    end
    wr_pend = mem_we; wr_a = mem_addr; wr_d = mem_wdata;
    // Masters: a request is consumed in its grant cycle; otherwise it is held stable.
    if (m_cur == 0) begin void'(q0.pop_front()); act0 = 1'b0; end
    if (m_cur == 1) begin void'(q1.pop_front()); act1 = 1'b0; end
    if (!act0 && q0.size() > 0 && (cont || $urandom_range(1, 0) == 1)) act0 = 1'b1;
    if (!act1 && q1.size() > 0 && (cont || $urandom_range(1, 0) == 1)) act1 = 1'b1;
    req0 = act0;
    req1 = act1;
    if (q0.size() > 0) begin we0 = q0[0].we; addr0 = q0[0].addr; wdata0 = q0[0].wdata; end
    if (q1.size() > 0) begin we1 = q1[0].we; addr1 = q1[0].addr; wdata1 = q1[0].wdata; end
    reset = rst_in;
    @(posedge clk);
    #1;
    if (wr_pend === 1'b1) mem[wr_a] = wr_d;
    model_edge();
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while ((q0.size() > 0 || q1.size() > 0 || m_cur >= 0 || m_rv >= 0) && n < budget) begin
      step(1'b0);
      n++;
    end
    check_eq("drain", 32'(q0.size() + q1.size()), 32'd0);
    step(1'b0);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      mem[i]     = 8'($urandom);
      mem_ref[i] = mem[i];
    end
    mem[8'h10] = 8'hA5; mem_ref[8'h10] = 8'hA5;
    mem[8'h05] = 8'h5A; mem_ref[8'h05] = 8'h5A;
    cont = 1'b1;

    step(1'b1);
    step(1'b1);
    step(1'b0);

    // Single read from port 0
    push(0, 1'b0, 8'h10, 8'h00);
    drain(20);

    // Port 1 write, then read it back
    push(1, 1'b1, 8'h20, 8'h3C);
    drain(20);
    check_eq("mem20", 32'(mem[8'h20]), 32'h3C);
    push(1, 1'b0, 8'h20, 8'h00);
    drain(20);

    // Both ports requesting continuously
    for (int i = 0; i < 4; i++) begin
      push(0, 1'b0, 8'h01, 8'h00);
      push(1, 1'b0, 8'h02, 8'h00);
    end
    drain(60);

    // Back-to-back: port 1 writes the address port 0 is reading
    push(0, 1'b0, 8'h05, 8'h00);
    step(1'b0);
    push(1, 1'b1, 8'h05, 8'hFF);
    drain(20);
    push(0, 1'b0, 8'h05, 8'h00);
    drain(20);
    check_eq("mem05", 32'(mem[8'h05]), 32'hFF);

    // Reset during the access cycle of a read
    push(0, 1'b0, 8'h33, 8'h00);
    step(1'b0);
    step(1'b1);
    step(1'b0);
    check_eq("rst_idle", 32'(busy), 32'd0);
    drain(20);

    // Single-port streaming
    for (int i = 0; i < 4; i++) push(0, 1'b0, 8'(8'h40 + i), 8'h00);
    drain(30);

    // Random traffic with occasional resets
    cont = 1'b0;
    for (int c = 0; c < 500; c++) begin
      if ($urandom_range(3, 0) == 0) begin
        if ($urandom_range(1, 0) == 0) begin
          if (q0.size() < 4) push(0, 1'($urandom), 8'($urandom_range(15, 0)), 8'($urandom));
        end else begin
          if (q1.size() < 4) push(1, 1'($urandom), 8'($urandom_range(15, 0)), 8'($urandom));
        end
      end
      step($urandom_range(99, 0) == 0);
    end
    drain(200);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
